// File: rtl/bram_bus_pkg.sv
// Shared definitions for the BRAM trig/done request bus responder.
package bram_bus_pkg;

   localparam int BRAM_ADDR_W = 13;
   localparam int BRAM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_ACK  = 2'd2,
      WR_ACK  = 2'd3
   } state_t;

   localparam logic CH_RD = 1'b0;
   localparam logic CH_WR = 1'b1;

endpackage

// File: rtl/bram_req_chan.sv
// One request channel: edge-qualifying armed flag, pending request and
// payload (address, plus data for writes) latched at the grant edge.
module bram_req_chan #(
   parameter int PAY_W = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic [PAY_W-1:0] payload,
   input  logic             grant,
   input  logic             done,
   output logic             pending,
   output logic [PAY_W-1:0] payload_q
);

   logic armed;

   assign pending = trig & armed;

   // A low trig always re-arms, so a trig that drops mid-transaction
   // cannot leave the channel disarmed and swallow its next request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b1;
         payload_q <= '0;
      end else begin
         if (!trig) begin
            armed <= 1'b1;
         end else if (done) begin
            armed <= 1'b0;
         end
         if (grant) begin
            payload_q <= payload;
         end
      end
   end

endmodule

// File: rtl/bram_req_responder.sv
// Responder for the BRAM trig/done bus: arbitrates a read and a write
// channel onto one single-port BRAM and returns a one-cycle done pulse.
module bram_req_responder
   import bram_bus_pkg::*;
#(
   parameter int ADDR_W     = BRAM_ADDR_W,
   parameter int DATA_W     = BRAM_DATA_W,
   parameter int DEPTH      = 8192,
   parameter int RD_LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic [ADDR_W-1:0] i_rd_bram_addr,
   input  logic              i_rd_bram_trig,
   output logic [DATA_W-1:0] o_rd_bram_data,
   output logic              o_rd_bram_done,
   input  logic [ADDR_W-1:0] i_wr_bram_addr,
   input  logic [DATA_W-1:0] i_wr_bram_data,
   input  logic              i_wr_bram_trig,
   output logic              o_wr_bram_done,
   output logic              o_bram_en,
   output logic              o_bram_we,
   output logic [ADDR_W-1:0] o_bram_addr,
   output logic [DATA_W-1:0] o_bram_wdata,
   input  logic [DATA_W-1:0] i_bram_rdata,
   output logic              o_addr_err
);

   localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
   localparam logic [1:0]      CNT_INIT = 2'(RD_LATENCY - 1);

   function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} >= DEPTH_V);
   endfunction

   state_t                     state;
   logic                       ptr;
   logic [1:0]                 cnt;
   logic                       rd_pend, wr_pend;
   logic                       rd_grant, wr_grant;
   logic [ADDR_W-1:0]          rd_addr_q, wr_addr_q;
   logic [DATA_W-1:0]          wr_data_q;
   logic [ADDR_W+DATA_W-1:0]   wr_pay_q;

   bram_req_chan #(.PAY_W(ADDR_W)) u_rd_chan (
      .clk       (i_clk),
      .rst_n     (i_rstn),
      .trig      (i_rd_bram_trig),
      .payload   (i_rd_bram_addr),
      .grant     (rd_grant),
      .done      (state == RD_ACK),
      .pending   (rd_pend),
      .payload_q (rd_addr_q)
   );

   bram_req_chan #(.PAY_W(ADDR_W + DATA_W)) u_wr_chan (
      .clk       (i_clk),
      .rst_n     (i_rstn),
      .trig      (i_wr_bram_trig),
      .payload   ({i_wr_bram_data, i_wr_bram_addr}),
      .grant     (wr_grant),
      .done      (state == WR_ACK),
      .pending   (wr_pend),
      .payload_q (wr_pay_q)
   );

   assign wr_addr_q    = wr_pay_q[ADDR_W-1:0];
   assign wr_data_q    = wr_pay_q[ADDR_W+DATA_W-1:ADDR_W];
   // The write latch is itself a flop loaded at the grant edge, so it
   // serves directly as the registered BRAM write-data output.
   assign o_bram_wdata = wr_data_q;

   always_comb begin
      rd_grant = 1'b0;
      wr_grant = 1'b0;
      if (state == IDLE) begin
         if (rd_pend && wr_pend) begin
            rd_grant = (ptr == CH_RD);
            wr_grant = (ptr == CH_WR);
         end else begin
            rd_grant = rd_pend;
            wr_grant = wr_pend;
         end
      end
   end

   // Single-transaction FSM; strobes default low so every pulse lasts one cycle.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state          <= IDLE;
         ptr            <= CH_RD;
         cnt            <= '0;
         o_rd_bram_data <= '0;
         o_rd_bram_done <= 1'b0;
         o_wr_bram_done <= 1'b0;
         o_bram_en      <= 1'b0;
         o_bram_we      <= 1'b0;
         o_bram_addr    <= '0;
         o_addr_err     <= 1'b0;
      end else begin
         o_rd_bram_done <= 1'b0;
         o_wr_bram_done <= 1'b0;
         o_bram_en      <= 1'b0;
         o_bram_we      <= 1'b0;
         o_addr_err     <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_grant) begin
                  o_bram_en   <= !out_of_range(i_rd_bram_addr);
                  o_bram_addr <= i_rd_bram_addr;
                  cnt         <= CNT_INIT;
                  state       <= RD_WAIT;
                  if (wr_pend) begin
                     ptr <= CH_WR;
                  end
               end else if (wr_grant) begin
                  o_bram_en   <= !out_of_range(i_wr_bram_addr);
                  o_bram_we   <= !out_of_range(i_wr_bram_addr);
                  o_bram_addr <= i_wr_bram_addr;
                  state       <= WR_ACK;
                  if (rd_pend) begin
                     ptr <= CH_RD;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt == 2'd0) begin
                  state <= RD_ACK;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RD_ACK: begin
               o_rd_bram_done <= 1'b1;
               o_rd_bram_data <= out_of_range(rd_addr_q) ? '0 : i_bram_rdata;
               o_addr_err     <= out_of_range(rd_addr_q);
               state          <= IDLE;
            end
            WR_ACK: begin
               o_wr_bram_done <= 1'b1;
               o_addr_err     <= out_of_range(wr_addr_q);
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_req_responder.sv
// Directed bench: three responders (read latency 2, 1, 4) each backed by
// a behavioural BRAM model with a matching read pipeline.
module tb_bram_req_responder;

   logic        clk = 1'b0;
   logic        rstn;
   logic [13:0] rd_addr    [3];
   logic        rd_trig    [3];
   logic [31:0] rd_data    [3];
   logic        rd_done    [3];
   logic [13:0] wr_addr    [3];
   logic [31:0] wr_data    [3];
   logic        wr_trig    [3];
   logic        wr_done    [3];
   logic        bram_en    [3];
   logic        bram_we    [3];
   logic [13:0] bram_addr  [3];
   logic [31:0] bram_wdata [3];
   logic [31:0] bram_rdata [3];
   logic        addr_err   [3];

   int checks = 0;
   int fails  = 0;
   int en_cnt0 = 0;
   int rd_cnt0 = 0;
   int wr_cnt0 = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      logic [31:0] mem  [8192];
      logic [31:0] pipe [4];

      bram_req_responder #(
         .ADDR_W(14), .DATA_W(32), .DEPTH(8192), .RD_LATENCY(LAT)
      ) dut (
         .i_clk          (clk),
         .i_rstn         (rstn),
         .i_rd_bram_addr (rd_addr[g]),
         .i_rd_bram_trig (rd_trig[g]),
         .o_rd_bram_data (rd_data[g]),
         .o_rd_bram_done (rd_done[g]),
         .i_wr_bram_addr (wr_addr[g]),
         .i_wr_bram_data (wr_data[g]),
         .i_wr_bram_trig (wr_trig[g]),
         .o_wr_bram_done (wr_done[g]),
         .o_bram_en      (bram_en[g]),
         .o_bram_we      (bram_we[g]),
         .o_bram_addr    (bram_addr[g]),
         .o_bram_wdata   (bram_wdata[g]),
         .i_bram_rdata   (bram_rdata[g]),
         .o_addr_err     (addr_err[g])
      );

      always @(posedge clk) begin
         if (bram_en[g]) begin
            if (bram_we[g]) mem[bram_addr[g][12:0]] <= bram_wdata[g];
            else            pipe[0] <= mem[bram_addr[g][12:0]];
         end
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign bram_rdata[g] = pipe[LAT-1];
   end

   always @(negedge clk) begin
      if (bram_en[0]) en_cnt0++;
      if (rd_done[0]) rd_cnt0++;
      if (wr_done[0]) wr_cnt0++;
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_read(input int k, input logic [13:0] a, input int exp_edges,
                           input logic [31:0] exp_data, input logic exp_err);
      int n = 0;
      @(negedge clk);
      rd_addr[k] = a;
      rd_trig[k] = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 12 && n == 0; i++) begin
         @(posedge clk); #1;
         if (rd_done[k]) n = i;
      end
      check_output($sformatf("rd_latency[%0d]", k), 64'(n), 64'(exp_edges));
      check_output($sformatf("rd_data[%0d]", k), 64'(rd_data[k]), 64'(exp_data));
      check_output($sformatf("rd_err[%0d]", k), 64'(addr_err[k]), 64'(exp_err));
      @(negedge clk);
      rd_trig[k] = 1'b0;
      @(negedge clk);
   endtask

   task automatic apply_stimulus(input int k, input logic [13:0] a, input logic [31:0] d,
                                 input int hold, input logic exp_err);
      int n = 0;
      @(negedge clk);
      wr_addr[k] = a;
      wr_data[k] = d;
      wr_trig[k] = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 12 && n == 0; i++) begin
         @(posedge clk); #1;
         if (wr_done[k]) n = i;
      end
      check_output($sformatf("wr_latency[%0d]", k), 64'(n), 64'd1);
      check_output($sformatf("wr_err[%0d]", k), 64'(addr_err[k]), 64'(exp_err));
      repeat (hold + 1) @(negedge clk);
      wr_trig[k] = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_pair(input logic [13:0] ra, input logic [13:0] wa, input logic [31:0] wd,
                           output int t_rd, output int t_wr, output logic [31:0] rv);
      t_rd = 0;
      t_wr = 0;
      rv   = '0;
      @(negedge clk);
      rd_addr[0] = ra;
      wr_addr[0] = wa;
      wr_data[0] = wd;
      rd_trig[0] = 1'b1;
      wr_trig[0] = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         if (rd_done[0] && t_rd == 0) begin
            t_rd = i;
            rv   = rd_data[0];
            rd_trig[0] = 1'b0;
         end
         if (wr_done[0] && t_wr == 0) begin
            t_wr = i;
            wr_trig[0] = 1'b0;
         end
      end
      rd_trig[0] = 1'b0;
      wr_trig[0] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int t_rd, t_wr, e0, w0, r0;
      logic [31:0] rv;

      rstn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rd_addr[k] = '0; rd_trig[k] = 1'b0;
         wr_addr[k] = '0; wr_data[k] = '0; wr_trig[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_output("reset_en", 64'(bram_en[0]), 64'd0);
      check_output("reset_dones", 64'({rd_done[0], wr_done[0], addr_err[0]}), 64'd0);
      check_output("reset_data", 64'(rd_data[0]), 64'd0);
      check_output("reset_bus", 64'({bram_we[0], bram_addr[0], bram_wdata[0]}), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      $display("[TB] write then read at 20");
      apply_stimulus(0, 14'd20, 32'hDEADBEEF, 0, 1'b0);
      run_read(0, 14'd20, 3, 32'hDEADBEEF, 1'b0);

      $display("[TB] trig held after done");
      e0 = en_cnt0; w0 = wr_cnt0;
      apply_stimulus(0, 14'd30, 32'h11111111, 10, 1'b0);
      check_output("hold_done_count", 64'(wr_cnt0 - w0), 64'd1);
      check_output("hold_access_count", 64'(en_cnt0 - e0), 64'd1);

      $display("[TB] simultaneous requests");
      run_pair(14'd5, 14'd6, 32'hA5A50006, t_rd, t_wr, rv);
      check_output("pair1_rd_time", 64'(t_rd), 64'd3);
      check_output("pair1_wr_time", 64'(t_wr), 64'd5);
      run_pair(14'd5, 14'd5, 32'h0BADF00D, t_rd, t_wr, rv);
      check_output("pair2_wr_time", 64'(t_wr), 64'd1);
      check_output("pair2_rd_time", 64'(t_rd), 64'd5);
      check_output("pair2_rd_data", 64'(rv), 64'h0BADF00D);
      run_read(0, 14'd6, 3, 32'hA5A50006, 1'b0);

      $display("[TB] out of range");
      e0 = en_cnt0;
      run_read(0, 14'd8192, 3, 32'h0, 1'b1);
      check_output("oor_rd_no_access", 64'(en_cnt0 - e0), 64'd0);
      e0 = en_cnt0;
      apply_stimulus(0, 14'd9000, 32'h77777777, 0, 1'b1);
      check_output("oor_wr_no_access", 64'(en_cnt0 - e0), 64'd0);

      $display("[TB] reset during read wait");
      @(negedge clk);
      rd_addr[0] = 14'd20;
      rd_trig[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check_output("midrst_en", 64'(bram_en[0]), 64'd0);
      check_output("midrst_dones", 64'({rd_done[0], wr_done[0], addr_err[0]}), 64'd0);
      check_output("midrst_data", 64'(rd_data[0]), 64'd0);
      r0 = rd_cnt0;
      rd_trig[0] = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check_output("midrst_no_done", 64'(rd_cnt0 - r0), 64'd0);
      run_read(0, 14'd20, 3, 32'hDEADBEEF, 1'b0);

      $display("[TB] latency sweep");
      apply_stimulus(1, 14'd20, 32'h12345678, 0, 1'b0);
      run_read(1, 14'd20, 2, 32'h12345678, 1'b0);
      apply_stimulus(2, 14'd20, 32'hCAFE0001, 0, 1'b0);
      run_read(2, 14'd20, 5, 32'hCAFE0001, 1'b0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
